// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream slave and its buffer.
package axis_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // Packet tracker: between packets, or partway through one.
    typedef enum logic [0:0] {
        StIdle,
        StRecv
    } axis_state_e;

    // Bit width needed to index/count up to n-1, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_fifo.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEFAULT + 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = width_of(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count_next
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // Guard both sides so a stray push/pop can never overwrite or underflow.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rptr_q];

    // Occupancy after this cycle's push/pop; pointers wrap at the power-of-2 depth.
    always_comb begin
        count_next = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/axis_s.sv
// AXI-Stream slave: buffers beats, exposes a pop port and tracks packet lengths.
module axis_s
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned LEN_W  = width_of(MAX_LEN + 1),
    localparam int unsigned CW     = width_of(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              rst_n,
    input  logic              tvalid,
    output logic              tready,
    input  logic [DATA_W-1:0] tdata,
    input  logic              tlast,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_en,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              len_err
);

    logic              tready_q, tready_d;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     count_next;
    logic [DATA_W:0]   fifo_head;

    axis_state_e       state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  len_q, len_d;

    assign push     = tvalid & tready_q & ~fifo_full;
    assign pop      = rd_en & ~fifo_empty;
    assign tready   = tready_q;
    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_head[DATA_W-1:0];
    assign rd_last  = fifo_head[DATA_W];
    assign pkt_done = done_q;
    assign pkt_len  = len_q;
    assign len_err  = err_q;

    axis_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (aclk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wdata      ({tlast, tdata}),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count_next (count_next)
    );

    // tready looks ahead at next occupancy so it never depends on tvalid.
    always_comb begin
        tready_d = (count_next < CW'(DEPTH));
    end

    // Packet tracking: count accepted beats, close on tlast or at MAX_LEN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_inc = cnt_q + LEN_W'(1);
        if (push) begin
            unique case (state_q)
                StIdle: begin
                    if (tlast) begin
                        done_d = 1'b1;
                        len_d  = LEN_W'(1);
                    end else begin
                        cnt_d   = LEN_W'(1);
                        state_d = StRecv;
                    end
                end
                StRecv: begin
                    if (tlast) begin
                        done_d  = 1'b1;
                        len_d   = cnt_inc;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else if (cnt_inc == LEN_W'(MAX_LEN)) begin
                        // Overlong packet: flag it and count the rest as a new one.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Handshake and packet-tracking state registers.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            len_q    <= '0;
        end else begin
            tready_q <= tready_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            len_q    <= len_d;
        end
    end

endmodule
